// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: sequences one 1-D convolution pass (define CONV_STRIDE2_EN for stride-2 output positions)
module conv_window_scheduler #(
    parameter int FILT_LEN = 4,
    parameter int IN_LEN   = 16,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] filt_addr,
    output logic [AW-1:0] in_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          out_wr,
    output logic [AW-1:0] out_addr
);
`ifdef CONV_STRIDE2_EN
    localparam int N = (IN_LEN - FILT_LEN) / 2 + 1;
`else
    localparam int N = IN_LEN - FILT_LEN + 1;
`endif
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
    state_t        state;
    logic [AW-1:0] i;
    logic [AW-1:0] k;
    logic [AW-1:0] base;
`ifdef CONV_STRIDE2_EN
    assign base = i << 1;
`else
    assign base = i;
`endif
    // pass sequencing; mac strobes trail FETCH by the one-cycle memory read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            k         <= '0;
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_en    <= state == FETCH;
            mac_first <= state == FETCH && k == '0;
            case (state)
                IDLE: if (start) begin
                    i     <= '0;
                    k     <= '0;
                    state <= FETCH;
                end
                FETCH: if (k == AW'(FILT_LEN - 1)) begin
                    k     <= '0;
                    state <= DRAIN;
                end else k <= k + 1'b1;
                DRAIN: state <= WRITE;
                WRITE: if (out_ready) begin
                    if (i == AW'(N - 1)) state <= DONE;
                    else begin
                        i     <= i + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // addresses and strobes decoded from state so reset clears them immediately
    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        filt_addr = state == FETCH ? k : '0;
        in_addr   = state == FETCH ? base + k : '0;
        out_wr    = state == WRITE;
        out_addr  = state == WRITE ? i : '0;
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: random-data, random-backpressure check against a cycle schedule and convolution model
module tb_conv_window_scheduler;
    localparam int F = 4, L = 16, AW = 6, MAXC = 300;
`ifdef CONV_STRIDE2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int N = (L - F) / S + 1;

    logic clk = 0, rst = 1, start = 0, out_ready = 0, start1 = 0;
    logic busy, done, mac_en, mac_first, out_wr;
    logic [AW-1:0] filt_addr, in_addr, out_addr;
    logic busy1, done1, mac_en1, mac_first1, out_wr1;
    logic [AW-1:0] filt_addr1, in_addr1, out_addr1;

    always #5 clk = ~clk;

    conv_window_scheduler #(.FILT_LEN(F), .IN_LEN(L), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .busy(busy), .done(done),
        .filt_addr(filt_addr), .in_addr(in_addr), .mac_en(mac_en), .mac_first(mac_first),
        .out_wr(out_wr), .out_addr(out_addr));

    conv_window_scheduler #(.FILT_LEN(1), .IN_LEN(1), .AW(AW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .out_ready(1'b1), .busy(busy1), .done(done1),
        .filt_addr(filt_addr1), .in_addr(in_addr1), .mac_en(mac_en1), .mac_first(mac_first1),
        .out_wr(out_wr1), .out_addr(out_addr1));

    int checks = 0, failures = 0;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int filt_mem[F];
    int in_mem[L];
    int tbl[N];
    int fd, id, acc;
    bit tbl_clr = 0;
    // bench-side memories (one-cycle read), accumulator and output table
    always @(posedge clk) begin
        fd <= filt_addr < F ? filt_mem[filt_addr] : 0;
        id <= in_addr < L ? in_mem[in_addr] : 0;
        if (mac_en) acc <= mac_first ? fd * id : acc + fd * id;
        if (tbl_clr) for (int t = 0; t < N; t++) tbl[t] <= -1;
        else if (out_wr && out_ready && out_addr < N) tbl[out_addr] <= acc;
    end

    bit rdy[MAXC], stv[MAXC];
    bit e_busy[MAXC], e_done[MAXC], e_wr[MAXC], e_me[MAXC], e_mf[MAXC];
    int e_fa[MAXC], e_ia[MAXC], e_oa[MAXC];
    int done_c;

    task automatic build();
        int c = 1;
        for (int t = 0; t < MAXC; t++) begin
            e_busy[t] = 0; e_done[t] = 0; e_wr[t] = 0; e_me[t] = 0; e_mf[t] = 0;
            e_fa[t] = 0; e_ia[t] = 0; e_oa[t] = 0;
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < F; k++) begin
                e_fa[c] = k; e_ia[c] = S * i + k; e_me[c + 1] = 1; e_mf[c + 1] = k == 0;
                c++;
            end
            c++;
            while (c < MAXC - 3) begin
                e_wr[c] = 1; e_oa[c] = i;
                c++;
                if (rdy[c - 1]) break;
            end
        end
        e_done[c] = 1;
        for (int t = 1; t <= c; t++) e_busy[t] = 1;
        done_c = c;
    endtask

    task automatic setup(input bit rand_rdy, input bit rand_data);
        for (int t = 0; t < MAXC; t++) begin
            rdy[t] = (!rand_rdy || t >= 200) ? 1'b1 : ($urandom_range(3) != 0);
            stv[t] = t == 0;
        end
        for (int k = 0; k < F; k++) filt_mem[k] = rand_data ? int'($urandom_range(255)) : 1;
        for (int t = 0; t < L; t++) in_mem[t] = rand_data ? int'($urandom_range(255)) : t;
    endtask

    task automatic clear_tbl();
        @(posedge clk); #1 tbl_clr = 1;
        @(posedge clk); #1 tbl_clr = 0;
    endtask

    task automatic run_pass(input int stop);
        for (int c = 0; c < MAXC && c <= done_c + 1 && c < stop; c++) begin
            @(posedge clk); #1;
            start = stv[c]; out_ready = rdy[c];
            @(negedge clk);
            check("busy", busy, e_busy[c]);
            check("done", done, e_done[c]);
            check("filt_addr", filt_addr, e_fa[c]);
            check("in_addr", in_addr, e_ia[c]);
            check("mac_en", mac_en, e_me[c]);
            check("mac_first", mac_first, e_mf[c]);
            check("out_wr", out_wr, e_wr[c]);
            check("out_addr", out_addr, e_oa[c]);
        end
        start = 0;
    endtask

    task automatic check_tbl();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            int s = 0;
            for (int k = 0; k < F; k++) s += filt_mem[k] * in_mem[S * i + k];
            check("table", tbl[i], s);
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outs", {done, out_wr, mac_en, mac_first, filt_addr, in_addr, out_addr}, 0);
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 start1 = c == 0;
            @(negedge clk);
            check("f1_busy", busy1, c >= 1 && c <= 4);
            check("f1_mac", {mac_en1, mac_first1}, c == 2 ? 3 : 0);
            check("f1_wr", out_wr1, c == 3);
            check("f1_addr", out_addr1, 0);
            check("f1_done", done1, c == 4);
        end
        start1 = 0;
        setup(0, 0); build(); clear_tbl(); run_pass(MAXC); check_tbl();
        setup(0, 1); rdy[36] = 0; rdy[37] = 0; rdy[38] = 0; build(); clear_tbl(); run_pass(MAXC); check_tbl();
        setup(1, 1); stv[10] = 1; stv[40] = 1; build(); clear_tbl(); run_pass(MAXC); check_tbl();
        setup(1, 1); build(); run_pass(31);
        #1 rst = 1;
        #1 check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {done, out_wr, mac_en, mac_first, filt_addr, in_addr, out_addr}, 0);
        @(posedge clk); #1 rst = 0;
        clear_tbl();
        setup(1, 1); build(); run_pass(MAXC); check_tbl();
        for (int p = 0; p < 3; p++) begin
            setup(1, 1);
            stv[$urandom_range(2, 40)] = 1;
            build(); clear_tbl(); run_pass(MAXC); check_tbl();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
